// File: rtl/iob_clint_rtc_gen.sv
// Programmable tick generator feeding the CLINT real-time clock input.
// Divides clk_i into single-cycle rtc_o pulses and counts them; configured over an IOb CSR port.
module iob_clint_rtc_gen #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int DIV_W   = 16,
   parameter int DIV_RST = 99
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                arst_i,
   input  logic                iob_avalid,
   input  logic [ADDR_W-1:0]   iob_addr,
   input  logic [DATA_W-1:0]   iob_wdata,
   input  logic [DATA_W/8-1:0] iob_wstrb,
   output logic                iob_rvalid,
   output logic [DATA_W-1:0]   iob_rdata,
   output logic                iob_ready,
   output logic                rtc_o
);

   localparam logic [1:0] SEL_CTRL   = 2'd0;
   localparam logic [1:0] SEL_DIV    = 2'd1;
   localparam logic [1:0] SEL_TICKS  = 2'd2;
   localparam logic [1:0] SEL_STATUS = 2'd3;

   logic              en_q, en_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] ticks_q, ticks_d;
   logic              rtc_q, rtc_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              wr_req;
   logic              rd_req;
   logic              addr_hit;
   logic [1:0]        word_sel;
   logic              ctrl_wr;
   logic              div_wr_en;
   logic              clr;
   logic [DIV_W-1:0]  div_wr;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-DIV_W+1:0] unused_bits;

   assign wr_req   = iob_avalid & (|iob_wstrb);
   assign rd_req   = iob_avalid & ~(|iob_wstrb);
   assign word_sel = iob_addr[3:2];

   // Any address bit above the 16-byte window makes the access unmapped.
   generate
      if (ADDR_W > 4) begin : g_addr_hi
         assign addr_hit = ~(|iob_addr[ADDR_W-1:4]);
      end else begin : g_addr_flat
         assign addr_hit = 1'b1;
      end
   endgenerate

   assign unused_bits = {iob_addr[1:0], iob_wdata[DATA_W-1:DIV_W]};

   // Byte-lane merge of write data into the divider register.
   genvar gi;
   generate
      for (gi = 0; gi < DIV_W; gi++) begin : g_div_lane
         assign div_wr[gi] = iob_wstrb[gi/8] ? iob_wdata[gi] : div_q[gi];
      end
   endgenerate

   always_comb begin
      ctrl_wr   = wr_req & addr_hit & (word_sel == SEL_CTRL) & iob_wstrb[0];
      div_wr_en = wr_req & addr_hit & (word_sel == SEL_DIV);
      clr       = ctrl_wr & iob_wdata[1];
      en_d      = ctrl_wr ? iob_wdata[0] : en_q;
      div_d     = div_wr_en ? div_wr : div_q;
   end

   // Prescaler decision uses the register values before any same-edge CSR write.
   always_comb begin
      cnt_d   = cnt_q;
      ticks_d = ticks_q;
      rtc_d   = 1'b0;
      if (en_q & cke_i) begin
         if (cnt_q >= div_q) begin
            cnt_d   = '0;
            rtc_d   = 1'b1;
            ticks_d = ticks_q + DATA_W'(1);
         end else begin
            cnt_d   = cnt_q + DIV_W'(1);
         end
      end
      if (clr) begin
         cnt_d   = '0;
         ticks_d = '0;
         rtc_d   = 1'b0;
      end
   end

   always_comb begin
      rd_val = '0;
      if (addr_hit) begin
         case (word_sel)
            SEL_CTRL:   rd_val[0] = en_q;
            SEL_DIV:    rd_val[DIV_W-1:0] = div_q;
            SEL_TICKS:  rd_val = ticks_q;
            SEL_STATUS: rd_val[0] = en_q & cke_i;
            default:    rd_val = '0;
         endcase
      end
   end

   always_comb begin
      rvalid_d = rd_req;
      rdata_d  = rd_req ? rd_val : rdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         en_q     <= 1'b0;
         div_q    <= DIV_W'(DIV_RST);
         cnt_q    <= '0;
         ticks_q  <= '0;
         rtc_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         en_q     <= en_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         ticks_q  <= ticks_d;
         rtc_q    <= rtc_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign iob_ready  = ~arst_i;
   assign iob_rvalid = rvalid_q;
   assign iob_rdata  = rdata_q;
   assign rtc_o      = rtc_q;

endmodule

// File: doc/iob_clint_rtc_gen.md
Name: iob_clint_rtc_gen

Overview:
Programmable real-time tick generator that sits directly upstream of the CLINT and drives its real-time clock input (rt_clk). It divides clk_i into single-cycle tick pulses at a software-set rate and counts the ticks emitted. Software configures it through a native IOb slave CSR port. The CLINT's mtime then advances at a rate software controls, independent of core clock frequency.

Parameters:
ADDR_W, 4, CSR byte-address width (4 words used)
DATA_W, 32, CSR data width; fixed at 32
DIV_W, 16, prescaler/divider width
DIV_RST, 99, DIV register reset value (tick every 100 clk_i cycles)

Ports:
clk_i  in  1  system clock
cke_i  in  1  clock enable; 0 freezes the prescaler only
arst_i  in  1  reset, synchronous, active-high
iob_avalid  in  1  request valid
iob_addr  in  ADDR_W  byte address
iob_wdata  in  DATA_W  write data
iob_wstrb  in  DATA_W/8  byte strobes; all-zero = read
iob_rvalid  out  1  read data valid
iob_rdata  out  DATA_W  read data
iob_ready  out  1  request accepted
rtc_o  out  1  one-cycle tick pulse to CLINT rt_clk

Behaviour:
- Reset (arst_i=1 at posedge clk_i): EN=0, DIV=DIV_RST, cnt=0, TICKS=0, rtc_o=0, iob_rvalid=0, iob_rdata=0. Reset overrides every other event in the same cycle, including mid-count and mid-read.
- CSR map (byte addr): 0x0 CTRL: bit0 EN (rw); bit1 CLR (write-1 pulse, reads 0). 0x4 DIV: bits DIV_W-1:0 (rw), upper bits read 0. 0x8 TICKS: 32-bit tick count (ro, wraps 0xFFFFFFFF->0). 0xC STATUS: bit0 = EN & cke_i (ro).
- Bus: iob_ready constant 1 outside reset. Write: avalid & |wstrb; per-byte-lane update at the same edge. Read: avalid & ~|wstrb; iob_rdata registered from the value at the request edge; iob_rvalid=1 for exactly the following cycle. Back-to-back reads give one rvalid per request. Unmapped address: writes ignored; reads return 0 with rvalid.
- Prescaler, at each edge with EN=1 and cke_i=1: if cnt >= DIV then cnt<=0, rtc_o<=1, TICKS<=TICKS+1; else cnt<=cnt+1, rtc_o<=0. Tick period = DIV+1 cycles. DIV=0 gives rtc_o high every enabled cycle.
- EN=0 or cke_i=0: cnt and TICKS hold; rtc_o<=0.
- DIV write when cnt >= new DIV: the tick fires at the next evaluated edge, not a wrap of the DIV_W counter.
- CSR writes take effect at the request edge. The prescaler decision at that same edge uses the old EN/DIV. After writing EN=1, the first tick appears DIV+1 edges later.
- CLR=1 written: cnt<=0, TICKS<=0, rtc_o<=0. CLR wins over a simultaneous tick and increment. EN is written from the same wdata.
- Reading TICKS in the cycle of an increment returns the pre-increment value.
- rtc_o is always registered, glitch-free and never wider than one cycle, except when DIV=0 with continuous enable.

Test Plan:
- Reset, then read 0x4 and 0x8 -> rdata 99 then 0. rvalid high one cycle after each request. rtc_o=0.
- DIV=3, CTRL=1, run 12 cycles -> rtc_o pulses at edges 4, 8, 12 after the enable write. TICKS reads 3.
- DIV=0, EN=1 for 5 cycles -> rtc_o high for 5 consecutive cycles. TICKS=5.
- DIV=9, EN=1; at cnt=5 write DIV=2 -> tick on the next edge, then every 3 cycles.
- EN=1 with TICKS=7: write CTRL=0x3 on a tick-due edge -> TICKS=0, rtc_o=0 that cycle. Counting restarts; the first tick comes DIV+1 edges later.
- cke_i=0 for 4 cycles mid-count -> cnt and TICKS frozen, STATUS=0. The tick resumes 4 cycles late. arst_i mid-count -> all registers at reset values the next cycle.
